// File: rtl/iroh_mem_arbiter_if.sv
// Bundle of the two requester ports and the single-port memory port of the
// memory arbiter. The slave modport is the arbiter's view.
interface iroh_mem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_gnt;
  logic              m0_rvalid;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_gnt;
  logic              m1_rvalid;
  logic [DATA_W-1:0] m1_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/iroh_mem_arbiter.sv
// Two-port arbiter for the shared single-port instruction/data memory:
// one access at a time, registered command, read data returned with a pulse.
module iroh_mem_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 16,
  parameter int RD_LATENCY = 1,
  parameter int FIXED_PRIO = 0
) (
  input  logic                clk,
  input  logic                rst,
  iroh_mem_arbiter_if.slave   bus,
  output logic                busy
);
  localparam int CNT_W = $clog2(RD_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t            state, state_nx;
  logic              winner;
  logic              last_grant;
  logic              pick;
  logic              any_req;
  logic              cmd_we;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;
  logic              mem_en, mem_we;
  logic              gnt0, gnt1, rvalid0, rvalid1;

  // Tie goes to the port that did not win last time unless port 0 is pinned.
  always_comb begin
    any_req = bus.m0_req | bus.m1_req;
    if (bus.m0_req && bus.m1_req) begin
      pick = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
    end else begin
      pick = bus.m1_req;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      winner     <= 1'b0;
      last_grant <= 1'b1;
      cmd_we     <= 1'b0;
      cnt        <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && any_req) begin
        winner     <= pick;
        last_grant <= pick;
        cmd_we     <= pick ? bus.m1_we    : bus.m0_we;
        addr_q     <= pick ? bus.m1_addr  : bus.m0_addr;
        wdata_q    <= pick ? bus.m1_wdata : bus.m0_wdata;
      end
      if (state == ACCESS) begin
        cnt <= CNT_W'(RD_LATENCY);
      end else if (state == WAIT) begin
        cnt <= cnt - CNT_W'(1);
      end
      // Loading the port register on the last WAIT edge makes it visible exactly in RESP.
      if (state == WAIT && cnt == CNT_W'(1)) begin
        if (winner) begin
          rdata1_q <= bus.mem_rdata;
        end else begin
          rdata0_q <= bus.mem_rdata;
        end
      end
    end
  end

  always_comb begin
    state_nx = state;
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    rvalid0  = 1'b0;
    rvalid1  = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) state_nx = ACCESS;
      end
      ACCESS: begin
        mem_en   = 1'b1;
        mem_we   = cmd_we;
        gnt0     = ~winner;
        gnt1     = winner;
        state_nx = cmd_we ? IDLE : WAIT;
      end
      WAIT: begin
        if (cnt == CNT_W'(1)) state_nx = RESP;
      end
      RESP: begin
        rvalid0  = ~winner;
        rvalid1  = winner;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.m0_gnt    = gnt0;
  assign bus.m1_gnt    = gnt1;
  assign bus.m0_rvalid = rvalid0;
  assign bus.m1_rvalid = rvalid1;
  assign bus.m0_rdata  = rdata0_q;
  assign bus.m1_rdata  = rdata1_q;
  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign busy          = (state != IDLE);
endmodule

// File: tb/tb_iroh_mem_arbiter.sv
// Bench for iroh_mem_arbiter: three configurations (round-robin, fixed priority,
// read latency 3) driven by random requesters, checked every cycle against a model.
module tb_iroh_mem_arbiter;
  localparam int AW = 8;
  localparam int DW = 16;

  typedef struct {
    bit          we;
    logic [7:0]  addr;
    logic [15:0] wdata;
  } cmd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int          cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  bit          chk_en = 1'b0;
  bit          go = 1'b0;
  bit          rand_phase = 1'b0;
  bit          hold_both = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] init_word(input int unsigned a);
    if (a == 5) return 16'hBEEF;
    return 16'((a * 40503) ^ 23130);
  endfunction

  function automatic cmd_t rand_cmd(input bit rd_only);
    cmd_t c;
    c.we    = !rd_only && ($urandom_range(0, 3) == 0);
    c.addr  = 8'($urandom_range(0, 15));
    if ($urandom_range(0, 7) == 0) c.addr = 8'($urandom);
    c.wdata = 16'($urandom);
    return c;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L  = (g == 2) ? 3 : 1;
    localparam int FP = (g == 1) ? 1 : 0;

    iroh_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
    logic busy;

    iroh_mem_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(L), .FIXED_PRIO(FP)
    ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus),
      .busy(busy)
    );

    // Memory with RD_LATENCY pipeline; a recognisable filler word outside the valid slot.
    logic [15:0] mem [256];
    bit          mem_init = 1'b0;
    logic [7:0]  ra [L];
    bit          rv [L];
    always @(posedge clk) begin
      if (!mem_init) begin
        for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        mem_init <= 1'b1;
      end else if (bus.mem_en && bus.mem_we) begin
        mem[bus.mem_addr] <= bus.mem_wdata;
      end
      rv[0] <= bus.mem_en && !bus.mem_we;
      ra[0] <= bus.mem_addr;
      for (int i = 1; i < L; i++) begin
        rv[i] <= rv[i-1];
        ra[i] <= ra[i-1];
      end
    end
    assign bus.mem_rdata = rv[L-1] ? mem[ra[L-1]] : 16'h0BAD;

    // Requesters: hold a command until granted, then present the next one.
    cmd_t dq0[$], dq1[$];
    cmd_t cur0, cur1;
    bit   pend0, pend1;
    initial begin
      cmd_t c;
      pend0 = 0; pend1 = 0;
      c.we = 0; c.addr = 8'h05; c.wdata = 16'h0; dq0.push_back(c);
      c.we = 0; c.addr = 8'h10; c.wdata = 16'h0; dq0.push_back(c);
      c.we = 1; c.addr = 8'h10; c.wdata = 16'h1234; dq1.push_back(c);
      cur0 = c; cur1 = c;
      bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = '0; bus.m0_wdata = '0;
      bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = '0; bus.m1_wdata = '0;
      forever begin
        @(negedge clk);
        if (bus.m0_gnt) pend0 = 0;
        if (bus.m1_gnt) pend1 = 0;
        if (go && !pend0) begin
          if (dq0.size() > 0) begin cur0 = dq0.pop_front(); pend0 = 1; end
          else if (rand_phase && (hold_both || $urandom_range(0, 2) == 0)) begin
            cur0 = rand_cmd(hold_both); pend0 = 1;
          end
        end
        if (go && !pend1) begin
          if (dq1.size() > 0) begin cur1 = dq1.pop_front(); pend1 = 1; end
          else if (rand_phase && (hold_both || $urandom_range(0, 2) == 0)) begin
            cur1 = rand_cmd(hold_both); pend1 = 1;
          end
        end
        bus.m0_req = pend0; bus.m0_we = cur0.we; bus.m0_addr = cur0.addr; bus.m0_wdata = cur0.wdata;
        bus.m1_req = pend1; bus.m1_we = cur1.we; bus.m1_addr = cur1.addr; bus.m1_wdata = cur1.wdata;
      end
    end

    // Reference model: one access at a time, timed from the cycle it is first seen.
    logic [15:0] shadow [256];
    bit          sh_init = 1'b0;
    bit          act = 1'b0;
    bit          m_port, m_we, last;
    int          ready = 0, g_cyc = 0, r_cyc = 0;
    logic [7:0]  e_addr;
    logic [15:0] e_wdata, rd_val;
    logic [15:0] e_rd [2];

    always @(posedge clk) begin
      if (!sh_init) begin
        for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
        sh_init = 1'b1;
      end
      if (rst) begin
        act = 0; ready = cyc + 1; last = 1;
        e_addr = '0; e_wdata = '0; e_rd[0] = '0; e_rd[1] = '0;
      end else begin
        if (act && !m_we && cyc + 1 == r_cyc) e_rd[m_port] = rd_val;
        if (cyc >= ready && (bus.m0_req || bus.m1_req)) begin
          if (bus.m0_req && bus.m1_req) m_port = (FP != 0) ? 1'b0 : !last;
          else m_port = bus.m1_req;
          last    = m_port;
          act     = 1;
          g_cyc   = cyc + 1;
          m_we    = m_port ? bus.m1_we : bus.m0_we;
          e_addr  = m_port ? bus.m1_addr : bus.m0_addr;
          e_wdata = m_port ? bus.m1_wdata : bus.m0_wdata;
          if (m_we) begin
            shadow[e_addr] = e_wdata;
            ready = cyc + 2;
          end else begin
            rd_val = shadow[e_addr];
            r_cyc  = cyc + 2 + L;
            ready  = cyc + 3 + L;
          end
        end
      end
    end

    always @(negedge clk) begin
      if (chk_en) begin
        bit eg, er, eb;
        eg = act && cyc == g_cyc;
        er = act && !m_we && cyc == r_cyc;
        eb = act && cyc >= g_cyc && cyc < ready;
        check_eq($sformatf("d%0d_m0_gnt", g), bus.m0_gnt, eg && !m_port);
        check_eq($sformatf("d%0d_m1_gnt", g), bus.m1_gnt, eg && m_port);
        check_eq($sformatf("d%0d_m0_rvalid", g), bus.m0_rvalid, er && !m_port);
        check_eq($sformatf("d%0d_m1_rvalid", g), bus.m1_rvalid, er && m_port);
        check_eq($sformatf("d%0d_m0_rdata", g), bus.m0_rdata, e_rd[0]);
        check_eq($sformatf("d%0d_m1_rdata", g), bus.m1_rdata, e_rd[1]);
        check_eq($sformatf("d%0d_mem_en", g), bus.mem_en, eg);
        check_eq($sformatf("d%0d_mem_we", g), bus.mem_we, eg && m_we);
        check_eq($sformatf("d%0d_mem_addr", g), bus.mem_addr, e_addr);
        check_eq($sformatf("d%0d_mem_wdata", g), bus.mem_wdata, e_wdata);
        check_eq($sformatf("d%0d_busy", g), busy, eb);
      end
    end
  end

  initial begin
    bit seen;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    go = 1'b1;
    rand_phase = 1'b1;

    repeat (800) @(negedge clk);
    hold_both = 1'b1;
    repeat (400) @(negedge clk);
    hold_both = 1'b0;
    repeat (800) @(negedge clk) rst = ($urandom_range(0, 149) == 0);
    rst = 1'b0;

    // Reset landing in the first WAIT cycle of a latency-3 read, both ports requesting.
    hold_both = 1'b1;
    repeat (10) @(negedge clk);
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = g_dut[2].bus.m0_gnt || g_dut[2].bus.m1_gnt;
    end
    check_eq("wait_gnt_timeout", seen, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = g_dut[2].bus.m0_gnt || g_dut[2].bus.m1_gnt;
    end
    check_eq("rst_tie_gnt_seen", seen, 1);
    check_eq("rst_tie_m0_wins", g_dut[2].bus.m0_gnt, 1);
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
